// File: rtl/alut_age_sweep16.sv
// Age sweeper for the ALUT age port: walks every entry and clears the valid bit of entries older than the threshold.
// Optional sticky interrupt and irq_clr16 port are enabled with `define ALUT_AGE_IRQ_EN.
module alut_age_sweep16 #(
  parameter int DW16  = 83,
  parameter int DD16  = 256,
  parameter int AW16  = 8,
  parameter int TSW16 = 32
) (
  input  logic              pclk16,
  input  logic              p_reset16,
  input  logic              sweep_start16,
  input  logic [TSW16-1:0]  curr_time16,
  input  logic [TSW16-1:0]  age_threshold16,
  input  logic              add_active16,
  input  logic [DW16-1:0]   mem_read_data_age16,
`ifdef ALUT_AGE_IRQ_EN
  input  logic              irq_clr16,
`endif
  output logic [AW16-1:0]   mem_addr_age16,
  output logic              mem_write_age16,
  output logic [DW16-1:0]   mem_write_data_age16,
  output logic              sweep_busy16,
  output logic              sweep_done16,
  output logic [AW16:0]     aged_count16,
  output logic              age_irq16
);

  localparam int VALID_BIT = DW16 - 1;
  localparam int TS_LSB    = DW16 - 1 - TSW16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [AW16-1:0] LAST_ADDR = AW16'(DD16 - 1);
  localparam logic [AW16:0]   COUNT_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic [AW16-1:0]  addr_q, addr_d;
  logic [DW16-1:0]  entry_q, entry_d;
  logic [AW16:0]    count_q, count_d;
  logic [TSW16-1:0] age_s;
  logic             expired_s;

  // Modular subtraction makes the age correct across a timestamp wrap.
  always_comb begin
    age_s     = curr_time16 - mem_read_data_age16[TS_LSB +: TSW16];
    expired_s = mem_read_data_age16[VALID_BIT] && (age_s > age_threshold16);
  end

  // Next-state logic for the sweep walk.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    entry_d = entry_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_start16) begin
          addr_d  = '0;
          count_d = '0;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (add_active16) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (add_active16) begin
          state_d = ST_READ;
        end else if (expired_s) begin
          entry_d            = mem_read_data_age16;
          entry_d[VALID_BIT] = 1'b0;
          state_d            = ST_WRITE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + AW16'(1);
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (add_active16) begin
          state_d = ST_READ;
        end else begin
          if (count_q != COUNT_MAX) begin
            count_d = count_q + (AW16+1)'(1);
          end else begin
            count_d = count_q;
          end
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + AW16'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sweep state registers.
  always_ff @(posedge pclk16) begin
    if (p_reset16) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      entry_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

`ifdef ALUT_AGE_IRQ_EN
  logic irq_q, irq_d;

  // Sticky interrupt; a set in the DONE cycle beats a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr16) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
    if ((state_q == ST_DONE) && (count_q != '0)) begin
      irq_d = 1'b1;
    end else begin
      irq_d = irq_d;
    end
  end

  // Interrupt register.
  always_ff @(posedge pclk16) begin
    if (p_reset16) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign age_irq16 = irq_q;
`else
  assign age_irq16 = 1'b0;
`endif

  // The write strobe yields combinationally to the address checker and to reset.
  assign mem_addr_age16       = addr_q;
  assign mem_write_age16      = (state_q == ST_WRITE) && !add_active16 && !p_reset16;
  assign mem_write_data_age16 = entry_q;
  assign sweep_busy16         = (state_q != ST_IDLE);
  assign sweep_done16         = (state_q == ST_DONE);
  assign aged_count16         = count_q;

endmodule

// File: tb/tb_alut_age_sweep16.sv
// Self-checking bench for alut_age_sweep16 with a behavioural memory and an aging reference model.
module tb_alut_age_sweep16;

  logic          pclk16;
  logic          p_reset16;
  logic          sweep_start16;
  logic [31:0]   curr_time16;
  logic [31:0]   age_threshold16;
  logic          add_active16;
  logic [82:0]   mem_read_data_age16;
  logic [7:0]    mem_addr_age16;
  logic          mem_write_age16;
  logic [82:0]   mem_write_data_age16;
  logic          sweep_busy16;
  logic          sweep_done16;
  logic [8:0]    aged_count16;
  logic          age_irq16;
`ifdef ALUT_AGE_IRQ_EN
  logic          irq_clr16;
`endif

  alut_age_sweep16 dut (
    .pclk16               (pclk16),
    .p_reset16            (p_reset16),
    .sweep_start16        (sweep_start16),
    .curr_time16          (curr_time16),
    .age_threshold16      (age_threshold16),
    .add_active16         (add_active16),
    .mem_read_data_age16  (mem_read_data_age16),
`ifdef ALUT_AGE_IRQ_EN
    .irq_clr16            (irq_clr16),
`endif
    .mem_addr_age16       (mem_addr_age16),
    .mem_write_age16      (mem_write_age16),
    .mem_write_data_age16 (mem_write_data_age16),
    .sweep_busy16         (sweep_busy16),
    .sweep_done16         (sweep_done16),
    .aged_count16         (aged_count16),
    .age_irq16            (age_irq16)
  );

  initial pclk16 = 1'b0;
  always #5 pclk16 = ~pclk16;

  logic [82:0] img [256];
  logic [82:0] mem [256];
  logic [82:0] final_img [256];
  logic        load_req;
  logic [7:0]  wr_addr_log [1024];
  logic [82:0] wr_data_log [1024];
  int          wr_cnt;
  int          exp_addr [256];
  logic [82:0] exp_data [256];
  int          exp_n;
  logic        irq_exp;
  int          checks;
  int          errors;

  // Memory model: registered read, age-port write, and a write log.
  always @(posedge pclk16) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wr_cnt <= 0;
    end else if (mem_write_age16) begin
      mem[mem_addr_age16] <= mem_write_data_age16;
      if (wr_cnt < 1024) begin
        wr_addr_log[wr_cnt] <= mem_addr_age16;
        wr_data_log[wr_cnt] <= mem_write_data_age16;
      end
      wr_cnt <= wr_cnt + 1;
    end
    mem_read_data_age16 <= mem[mem_addr_age16];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load();
    load_req = 1'b1;
    @(negedge pclk16);
    load_req = 1'b0;
  endtask

  // Reference: every valid entry with (time - ts) mod 2^32 > threshold is written back invalid, in address order.
  task automatic model(input logic [31:0] t, input logic [31:0] thr);
    logic [82:0] e;
    logic [31:0] age;
    exp_n = 0;
    for (int i = 0; i < 256; i++) begin
      e   = img[i];
      age = t - e[81:50];
      if (e[82] && (age > thr)) begin
        e[82] = 1'b0;
        exp_addr[exp_n] = i;
        exp_data[exp_n] = e;
        exp_n++;
      end
      final_img[i] = e;
    end
  endtask

  task automatic run_sweep(input int mode, output int n);
    int stalls;
    int cnt5;
    bit stalled;
    stalls = 0; cnt5 = 0; stalled = 1'b0;
    @(negedge pclk16);
    sweep_start16 = 1'b1;
    @(negedge pclk16);
    sweep_start16 = 1'b0;
    n = 1;
    check("first_read_addr", 128'(mem_addr_age16), 128'(0));
    check("busy_after_start", 128'(sweep_busy16), 128'(1));
    while (!sweep_done16 && n < 5000) begin
      add_active16 = 1'b0;
      if (mode == 1) begin
        add_active16 = ($urandom_range(0, 4) == 0);
      end else if (mode == 2 && mem_addr_age16 == 8'd7 && stalls < 3) begin
        add_active16 = 1'b1;
        stalls++;
        check("stall_addr_hold", 128'(mem_addr_age16), 128'(7));
        check("stall_no_write", 128'(mem_write_age16), 128'(0));
      end else if (mode == 3 && mem_addr_age16 == 8'd5) begin
        cnt5++;
        add_active16 = (cnt5 == 2);
      end else if (mode == 4 && mem_write_age16 && mem_addr_age16 == 8'd5 && !stalled) begin
        add_active16 = 1'b1;
        stalled = 1'b1;
        #1;
        check("write_yields", 128'(mem_write_age16), 128'(0));
      end
      @(negedge pclk16);
      n++;
    end
    add_active16 = 1'b0;
    check("done_pulse", 128'(sweep_done16), 128'(1));
    sweep_start16 = 1'b1;
    @(negedge pclk16);
    sweep_start16 = 1'b0;
    check("done_one_cycle", 128'(sweep_done16), 128'(0));
    check("idle_after_done", 128'(sweep_busy16), 128'(0));
  endtask

  task automatic verify(input string name, input int n, input int exp_cycles);
    int mism;
    model(curr_time16, age_threshold16);
    irq_exp = irq_exp | (exp_n != 0);
    check({name, "_writes"}, 128'(wr_cnt), 128'(exp_n));
    for (int i = 0; i < exp_n && i < wr_cnt; i++) begin
      check({name, "_waddr"}, 128'(wr_addr_log[i]), 128'(exp_addr[i]));
      check({name, "_wdata"}, 128'(wr_data_log[i]), 128'(exp_data[i]));
    end
    check({name, "_aged"}, 128'(aged_count16), 128'(exp_n));
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== final_img[i]) mism++;
    check({name, "_mem"}, 128'(mism), 128'(0));
    if (exp_cycles >= 0) check({name, "_cycles"}, 128'(n), 128'(exp_cycles));
`ifdef ALUT_AGE_IRQ_EN
    check({name, "_irq"}, 128'(age_irq16), 128'(irq_exp));
`else
    check({name, "_irq"}, 128'(age_irq16), 128'(0));
`endif
  endtask

  task automatic clear_irq();
`ifdef ALUT_AGE_IRQ_EN
    @(negedge pclk16);
    irq_clr16 = 1'b1;
    @(negedge pclk16);
    irq_clr16 = 1'b0;
`else
    @(negedge pclk16);
`endif
    irq_exp = 1'b0;
    check("irq_cleared", 128'(age_irq16), 128'(0));
  endtask

  task automatic blank_img();
    logic [63:0] r;
    for (int i = 0; i < 256; i++) begin
      r = {$urandom, $urandom};
      img[i] = {1'b0, r[63:32], r[49:0]};
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] ts;
    logic [31:0] t;
    logic [31:0] thr;
    int          aged;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    bit found;
    logic [63:0] r;
    logic [31:0] ts;
    checks = 0; errors = 0; irq_exp = 1'b0;
    load_req = 1'b0; wr_cnt = 0;
    p_reset16 = 1'b1; sweep_start16 = 1'b0; add_active16 = 1'b0;
    curr_time16 = 32'd0; age_threshold16 = 32'd0;
`ifdef ALUT_AGE_IRQ_EN
    irq_clr16 = 1'b0;
`endif
    blank_img();

    vecs[0] = '{1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_001F, 1};
    vecs[1] = '{1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0020, 0};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 0};
    vecs[3] = '{1'b1, 32'h0000_04D2, 32'h0000_04D2, 32'h0000_0000, 0};
    vecs[4] = '{1'b1, 32'h0000_04D1, 32'h0000_04D2, 32'h0000_0000, 1};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_03E8, 32'h0000_0000, 0};
    vecs[6] = '{1'b1, 32'h0000_03E8, 32'h0000_0000, 32'h0000_01F4, 1};
    vecs[7] = '{1'b1, 32'h0000_01F4, 32'h0000_03E8, 32'h0000_01F4, 0};

    repeat (3) @(negedge pclk16);
    p_reset16 = 1'b0;
    check("rst_busy", 128'(sweep_busy16), 128'(0));
    check("rst_done", 128'(sweep_done16), 128'(0));
    check("rst_write", 128'(mem_write_age16), 128'(0));
    check("rst_addr", 128'(mem_addr_age16), 128'(0));
    check("rst_wdata", 128'(mem_write_data_age16), 128'(0));
    check("rst_aged", 128'(aged_count16), 128'(0));
    check("rst_irq", 128'(age_irq16), 128'(0));

    // Single-entry threshold and wrap-around vectors at entry 0.
    for (int i = 0; i < 8; i++) begin
      blank_img();
      img[0] = {vecs[i].v, vecs[i].ts, 2'b01, 48'h0011_2233_4455};
      curr_time16 = vecs[i].t;
      age_threshold16 = vecs[i].thr;
      load();
      run_sweep(0, n);
      check($sformatf("vec%0d_count", i), 128'(aged_count16), 128'(vecs[i].aged));
      check($sformatf("vec%0d_valid", i), 128'(mem[0][82]), 128'(vecs[i].v && (vecs[i].aged == 0)));
      verify($sformatf("vec%0d", i), n, 513 + vecs[i].aged);
    end
    clear_irq();

    // Basic sweep: entry 5 aged, entry 9 too young.
    blank_img();
    img[5] = {1'b1, 32'd100, 2'b10, 48'hA5A5_0000_1234};
    img[9] = {1'b1, 32'd990, 2'b11, 48'h0000_BEEF_0009};
    curr_time16 = 32'd1000; age_threshold16 = 32'd500;
    load();
    run_sweep(0, n);
    check("basic_wdata", 128'(wr_data_log[0]), 128'({1'b0, 32'd100, 2'b10, 48'hA5A5_0000_1234}));
    verify("basic", n, 514);
    clear_irq();

    // Contention on the READ of addr 7: three extra cycles, no writes.
    blank_img();
    load();
    run_sweep(2, n);
    verify("stall_read", n, 516);

    // Contention in CHECK and in WRITE of aged addr 5: one write in the end.
    blank_img();
    img[5] = {1'b1, 32'd100, 2'b10, 48'hA5A5_0000_1234};
    load();
    run_sweep(3, n);
    verify("stall_check", n, 516);
    load();
    run_sweep(4, n);
    verify("stall_write", n, 517);
    clear_irq();

    // Two aged entries set the interrupt; a clean sweep leaves it cleared.
    img[9] = {1'b1, 32'd990, 2'b11, 48'h0000_BEEF_0009};
    curr_time16 = 32'd2000;
    load();
    run_sweep(0, n);
    verify("two_aged", n, 515);
    clear_irq();
    age_threshold16 = 32'hFFFF_FFFF;
    load();
    run_sweep(0, n);
    verify("none_aged", n, 513);

    // Reset during the WRITE of addr 12.
    blank_img();
    img[3]  = {1'b1, 32'd0, 2'b00, 48'h3333_3333_3333};
    img[12] = {1'b1, 32'd0, 2'b01, 48'hCCCC_CCCC_CCCC};
    curr_time16 = 32'd1000; age_threshold16 = 32'd500;
    load();
    sweep_start16 = 1'b1;
    @(negedge pclk16);
    sweep_start16 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (mem_write_age16 && mem_addr_age16 == 8'd12) found = 1'b1;
      else @(negedge pclk16);
    end
    check("reach_write12", 128'(found), 128'(1));
    p_reset16 = 1'b1;
    #1;
    check("rst_cycle_write", 128'(mem_write_age16), 128'(0));
    @(negedge pclk16);
    p_reset16 = 1'b0;
    irq_exp = 1'b0;
    check("midrst_busy", 128'(sweep_busy16), 128'(0));
    check("midrst_aged", 128'(aged_count16), 128'(0));
    check("midrst_addr", 128'(mem_addr_age16), 128'(0));
    check("midrst_wdata", 128'(mem_write_data_age16), 128'(0));
    check("midrst_irq", 128'(age_irq16), 128'(0));
    check("midrst_entry12", 128'(mem[12][82]), 128'(1));
    load();
    run_sweep(0, n);
    verify("after_rst", n, 515);

    // Randomised images with random contention.
    for (int s = 0; s < 4; s++) begin
      curr_time16 = $urandom;
      age_threshold16 = (s == 3) ? 32'd0 : 32'($urandom_range(0, 3000));
      for (int i = 0; i < 256; i++) begin
        r  = {$urandom, $urandom};
        ts = curr_time16 - 32'($urandom_range(0, 3000));
        img[i] = {r[63], ts, r[49:0]};
      end
      load();
      run_sweep(1, n);
      verify($sformatf("rand%0d", s), n, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
